// File: rtl/apb_gpio_slave.sv
// APB3 GPIO peripheral: output register, synchronised input port with
// rising-edge interrupt capture, programmable PREADY wait states and
// PSLVERR on misaligned, out-of-range or read-only-write accesses.
module apb_gpio_slave #(
  parameter int unsigned       GPIO_W     = 32,
  parameter logic [GPIO_W-1:0] OUT_RESET  = '0,
  parameter logic [3:0]        WAIT_RESET = 4'd0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              PSEL,
  input  logic [31:0]       PADDR,
  input  logic              PWRITE,
  input  logic              PENABLE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [GPIO_W-1:0] GPIO_IN,
  output logic [GPIO_W-1:0] GPIO_OUT,
  output logic              IRQ
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  // Register index = PADDR[4:2]
  localparam logic [2:0] IDX_DATA_OUT = 3'd0;
  localparam logic [2:0] IDX_DATA_IN  = 3'd1;
  localparam logic [2:0] IDX_WAIT_CFG = 3'd2;
  localparam logic [2:0] IDX_IRQ_STAT = 3'd3;
  localparam logic [2:0] IDX_IRQ_EN   = 3'd4;
  localparam logic [2:0] IDX_SCRATCH  = 3'd5;

  state_t            state;
  logic [3:0]        cnt;
  logic              rdy;
  logic              slverr;
  logic              err_q;
  logic              wr_q;
  logic [2:0]        idx_q;

  logic [GPIO_W-1:0] data_out;
  logic [3:0]        wait_cfg;
  logic [GPIO_W-1:0] irq_stat;
  logic [GPIO_W-1:0] irq_en;
  logic [31:0]       scratch;

  logic [GPIO_W-1:0] sync1;
  logic [GPIO_W-1:0] sync2;
  logic [GPIO_W-1:0] sync_prev;

  logic [7:0]        off;
  logic              setup;
  logic              dec_err;
  logic [31:0]       rd_snap;
  logic              commit;
  logic [GPIO_W-1:0] stat_clr;
  logic [GPIO_W-1:0] rise;

  // Only the low address byte is decoded; the rest is deliberately ignored.
  wire unused_paddr = &{1'b0, PADDR[31:8]};

  assign off      = PADDR[7:0];
  assign setup    = PSEL & ~PENABLE;
  assign dec_err  = (off[1:0] != 2'b00) | (off >= 8'h18) | (PWRITE & (off == 8'h04));
  assign commit   = (state == ACCESS) & PSEL & PENABLE & rdy & wr_q & ~err_q;
  assign stat_clr = (commit && (idx_q == IDX_IRQ_STAT)) ? PWDATA[GPIO_W-1:0] : '0;
  assign rise     = sync2 & ~sync_prev;

  assign PREADY   = rdy;
  assign PSLVERR  = slverr;
  assign GPIO_OUT = data_out;

  // Read snapshot for the transfer currently in its setup phase
  always_comb begin
    // NOTE: default assignment first so no path leaves rd_snap unassigned (no latch).
    rd_snap = '0;
    if (!dec_err && !PWRITE) begin
      case (off[4:2])
        IDX_DATA_OUT: rd_snap[GPIO_W-1:0] = data_out;
        IDX_DATA_IN:  rd_snap[GPIO_W-1:0] = sync2;
        IDX_WAIT_CFG: rd_snap[3:0]        = wait_cfg;
        IDX_IRQ_STAT: rd_snap[GPIO_W-1:0] = irq_stat;
        IDX_IRQ_EN:   rd_snap[GPIO_W-1:0] = irq_en;
        IDX_SCRATCH:  rd_snap             = scratch;
        default:      rd_snap             = '0;
      endcase
    end
  end

  // Transfer FSM: latches decode at setup, counts wait states, drives PREADY/PSLVERR/PRDATA
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      rdy    <= 1'b0;
      slverr <= 1'b0;
      err_q  <= 1'b0;
      wr_q   <= 1'b0;
      idx_q  <= 3'd0;
      PRDATA <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      case (state)
        IDLE: begin
          if (setup) begin
            state  <= ACCESS;
            err_q  <= dec_err;
            wr_q   <= PWRITE;
            idx_q  <= off[4:2];
            cnt    <= wait_cfg;
            rdy    <= (wait_cfg == 4'd0);
            slverr <= dec_err & (wait_cfg == 4'd0);
            PRDATA <= rd_snap;
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            // Master abandoned the transfer: nothing commits
            state  <= IDLE;
            rdy    <= 1'b0;
            slverr <= 1'b0;
            PRDATA <= '0;
          end else if (PENABLE) begin
            if (rdy) begin
              state  <= IDLE;
              rdy    <= 1'b0;
              slverr <= 1'b0;
              PRDATA <= '0;
            end else begin
              cnt    <= cnt - 4'd1;
              rdy    <= (cnt == 4'd1);
              slverr <= err_q & (cnt == 4'd1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register file writes, IRQ_STAT capture/clear (set wins) and registered IRQ
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      data_out <= OUT_RESET;
      wait_cfg <= WAIT_RESET;
      irq_stat <= '0;
      irq_en   <= '0;
      scratch  <= '0;
      IRQ      <= 1'b0;
    end else begin
      if (commit) begin
        case (idx_q)
          IDX_DATA_OUT: data_out <= PWDATA[GPIO_W-1:0];
          IDX_WAIT_CFG: wait_cfg <= PWDATA[3:0];
          IDX_IRQ_EN:   irq_en   <= PWDATA[GPIO_W-1:0];
          IDX_SCRATCH:  scratch  <= PWDATA;
          default:      ;
        endcase
      end
      irq_stat <= (irq_stat & ~stat_clr) | rise;
      IRQ      <= |(irq_stat & irq_en);
    end
  end

  // Two-flop input synchroniser plus previous-sample flop for edge detection
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
    end else begin
      sync1     <= GPIO_IN;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

endmodule

// File: tb/tb_apb_gpio_slave.sv
// Self-checking bench for apb_gpio_slave: scoreboarded APB transfers plus
// directed GPIO, interrupt, abort and mid-transfer reset scenarios.
module tb_apb_gpio_slave;

  localparam int unsigned GPIO_W   = 8;
  localparam logic [7:0]  OUT_RST  = 8'h3C;
  localparam logic [3:0]  WAIT_RST = 4'd2;

  localparam logic [31:0] A_DOUT = 32'h00;
  localparam logic [31:0] A_DIN  = 32'h04;
  localparam logic [31:0] A_WCFG = 32'h08;
  localparam logic [31:0] A_STAT = 32'h0C;
  localparam logic [31:0] A_EN   = 32'h10;
  localparam logic [31:0] A_SCR  = 32'h14;

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic              PSEL;
  logic [31:0]       PADDR;
  logic              PWRITE;
  logic              PENABLE;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic [GPIO_W-1:0] GPIO_IN;
  logic [GPIO_W-1:0] GPIO_OUT;
  logic              IRQ;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    bit          chk_rdata;
    logic        err;
    int          waits;
  } exp_t;

  exp_t sb[$];

  always #5 HCLK = ~HCLK;

  apb_gpio_slave #(
    .GPIO_W    (GPIO_W),
    .OUT_RESET (OUT_RST),
    .WAIT_RESET(WAIT_RST)
  ) dut (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .PSEL    (PSEL),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PENABLE (PENABLE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .GPIO_IN (GPIO_IN),
    .GPIO_OUT(GPIO_OUT),
    .IRQ     (IRQ)
  );

  task automatic idle();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(negedge HCLK);
  endtask

  // One APB transfer, started at a negedge; returns at the negedge after completion
  // with the bus still selected so the caller may chain a back-to-back setup.
  task automatic xfer(input string name, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err, input int exp_waits);
    exp_t e;
    exp_t g;
    int   k;
    e.name = name; e.rdata = exp_rdata; e.chk_rdata = (!wr) || exp_err;
    e.err = exp_err; e.waits = exp_waits;
    sb.push_back(e);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(negedge HCLK);
    PENABLE = 1'b1;
    k = 1;
    while (PREADY !== 1'b1 && k < 40) begin
      @(negedge HCLK);
      k++;
    end
    g = sb.pop_front();
    total++;
    if (PREADY !== 1'b1) begin
      bad++;
      $display("FAIL %s timeout: PREADY=%b after %0d access cycles, required 1", g.name, PREADY, k);
      idle();
      return;
    end
    total++;
    if ((k - 1) !== g.waits) begin
      bad++;
      $display("FAIL %s waits: got %0d required %0d", g.name, k - 1, g.waits);
    end
    total++;
    if (PSLVERR !== g.err) begin
      bad++;
      $display("FAIL %s pslverr: got %b required %b", g.name, PSLVERR, g.err);
    end
    if (g.chk_rdata) begin
      total++;
      if (PRDATA !== g.rdata) begin
        bad++;
        $display("FAIL %s prdata: got %h required %h", g.name, PRDATA, g.rdata);
      end
    end
    @(negedge HCLK);
    total++;
    if (PREADY !== 1'b0 || PSLVERR !== 1'b0) begin
      bad++;
      $display("FAIL %s after_done: got PREADY=%b PSLVERR=%b required 0 0", g.name, PREADY, PSLVERR);
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; GPIO_IN = '0;
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);
    total++;
    if (PRDATA !== 32'h0 || PREADY !== 1'b0 || PSLVERR !== 1'b0 || IRQ !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got PRDATA=%h PREADY=%b PSLVERR=%b IRQ=%b required 0", PRDATA, PREADY, PSLVERR, IRQ);
    end
    total++;
    if (GPIO_OUT !== OUT_RST) begin
      bad++;
      $display("FAIL reset_gpio_out: got %h required %h", GPIO_OUT, OUT_RST);
    end
    xfer("rst_wait_cfg", 1'b0, A_WCFG, 32'h0, {28'h0, WAIT_RST}, 1'b0, WAIT_RST);
    xfer("rst_data_out", 1'b0, A_DOUT, 32'h0, {24'h0, OUT_RST}, 1'b0, WAIT_RST);
    xfer("rst_irq_stat", 1'b0, A_STAT, 32'h0, 32'h0, 1'b0, WAIT_RST);
    xfer("rst_scratch",  1'b0, A_SCR,  32'h0, 32'h0, 1'b0, WAIT_RST);
    idle();
  endtask

  task automatic test_zero_wait();
    // Upper bits of WAIT_CFG are ignored, so this programs zero waits
    xfer("wcfg_wr0",   1'b1, A_WCFG, 32'hFFFF_FFF0, 32'h0, 1'b0, WAIT_RST);
    xfer("wcfg_rd0",   1'b0, A_WCFG, 32'h0, 32'h0, 1'b0, 0);
    xfer("dout_wr_a5", 1'b1, A_DOUT, 32'h0000_00A5, 32'h0, 1'b0, 0);
    total++;
    if (GPIO_OUT !== 8'hA5) begin
      bad++;
      $display("FAIL gpio_out_a5: got %h required a5", GPIO_OUT);
    end
    xfer("dout_rd_a5", 1'b0, A_DOUT, 32'h0, 32'h0000_00A5, 1'b0, 0);
    xfer("dout_wr_wide", 1'b1, A_DOUT, 32'hFFFF_FF5A, 32'h0, 1'b0, 0);
    xfer("dout_rd_wide", 1'b0, A_DOUT, 32'h0, 32'h0000_005A, 1'b0, 0);
    idle();
  endtask

  task automatic test_data_in();
    GPIO_IN = 8'h96;
    repeat (3) @(negedge HCLK);
    xfer("din_rd",     1'b0, A_DIN,  32'h0, 32'h0000_0096, 1'b0, 0);
    xfer("stat_edges", 1'b0, A_STAT, 32'h0, 32'h0000_0096, 1'b0, 0);
    xfer("stat_clr",   1'b1, A_STAT, 32'h0000_00FF, 32'h0, 1'b0, 0);
    xfer("stat_rd0",   1'b0, A_STAT, 32'h0, 32'h0, 1'b0, 0);
    idle();
  endtask

  task automatic test_wait_states();
    xfer("scr_wr",   1'b1, A_SCR,  32'hDEAD_BEEF, 32'h0, 1'b0, 0);
    xfer("wcfg_wr3", 1'b1, A_WCFG, 32'h3, 32'h0, 1'b0, 0);
    xfer("scr_rd_w3", 1'b0, A_SCR, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);
    xfer("wcfg_rd3", 1'b0, A_WCFG, 32'h0, 32'h3, 1'b0, 3);
    xfer("wcfg_wr0b", 1'b1, A_WCFG, 32'h0, 32'h0, 1'b0, 3);
    xfer("wcfg_rd0b", 1'b0, A_WCFG, 32'h0, 32'h0, 1'b0, 0);
    idle();
  endtask

  task automatic test_errors();
    xfer("err_wr_din",  1'b1, A_DIN,  32'h0000_0012, 32'h0, 1'b1, 0);
    xfer("err_rd_1c",   1'b0, 32'h1C, 32'h0, 32'h0, 1'b1, 0);
    xfer("err_wr_02",   1'b1, 32'h02, 32'h0000_0077, 32'h0, 1'b1, 0);
    xfer("err_rd_18",   1'b0, 32'h18, 32'h0, 32'h0, 1'b1, 0);
    xfer("err_rd_15",   1'b0, 32'h15, 32'h0, 32'h0, 1'b1, 0);
    total++;
    if (GPIO_OUT !== 8'h5A) begin
      bad++;
      $display("FAIL err_gpio_out: got %h required 5a", GPIO_OUT);
    end
    xfer("err_dout_kept", 1'b0, A_DOUT, 32'h0, 32'h0000_005A, 1'b0, 0);
    xfer("err_din_kept",  1'b0, A_DIN,  32'h0, 32'h0000_0096, 1'b0, 0);
    xfer("hi_addr_scr",   1'b0, 32'hABCD_0014, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
    idle();
  endtask

  task automatic test_back_to_back();
    xfer("b2b_scr_wr",  1'b1, A_SCR,  32'h1234_5678, 32'h0, 1'b0, 0);
    xfer("b2b_scr_rd",  1'b0, A_SCR,  32'h0, 32'h1234_5678, 1'b0, 0);
    xfer("b2b_dout_wr", 1'b1, A_DOUT, 32'h0000_00C3, 32'h0, 1'b0, 0);
    xfer("b2b_dout_rd", 1'b0, A_DOUT, 32'h0, 32'h0000_00C3, 1'b0, 0);
    xfer("b2b_err",     1'b0, 32'h20, 32'h0, 32'h0, 1'b1, 0);
    xfer("b2b_en_rd",   1'b0, A_EN,   32'h0, 32'h0, 1'b0, 0);
    idle();
  endtask

  task automatic test_irq();
    xfer("irq_en_wr", 1'b1, A_EN, 32'h1, 32'h0, 1'b0, 0);
    idle();
    GPIO_IN = 8'h00;
    repeat (4) @(negedge HCLK);
    GPIO_IN = 8'h01;
    repeat (3) @(negedge HCLK);
    total++;
    if (IRQ !== 1'b0) begin
      bad++;
      $display("FAIL irq_early: got %b required 0", IRQ);
    end
    @(negedge HCLK);
    total++;
    if (IRQ !== 1'b1) begin
      bad++;
      $display("FAIL irq_latency: got %b required 1", IRQ);
    end
    xfer("irq_stat_set", 1'b0, A_STAT, 32'h0, 32'h1, 1'b0, 0);
    xfer("irq_stat_w1c", 1'b1, A_STAT, 32'h1, 32'h0, 1'b0, 0);
    total++;
    if (IRQ !== 1'b1) begin
      bad++;
      $display("FAIL irq_clear_lag: got %b required 1", IRQ);
    end
    idle();
    total++;
    if (IRQ !== 1'b0) begin
      bad++;
      $display("FAIL irq_cleared: got %b required 0", IRQ);
    end
    xfer("irq_stat_rd0", 1'b0, A_STAT, 32'h0, 32'h0, 1'b0, 0);
    idle();
    // New edge lands on the same clock as the write-1-to-clear
    GPIO_IN = 8'h00;
    repeat (4) @(negedge HCLK);
    GPIO_IN = 8'h01;
    @(negedge HCLK);
    xfer("irq_coinc_w1c", 1'b1, A_STAT, 32'h1, 32'h0, 1'b0, 0);
    xfer("irq_set_wins",  1'b0, A_STAT, 32'h0, 32'h1, 1'b0, 0);
    idle();
    total++;
    if (IRQ !== 1'b1) begin
      bad++;
      $display("FAIL irq_after_coinc: got %b required 1", IRQ);
    end
    xfer("irq_en_off", 1'b1, A_EN, 32'h0, 32'h0, 1'b0, 0);
    idle();
    total++;
    if (IRQ !== 1'b0) begin
      bad++;
      $display("FAIL irq_masked: got %b required 0", IRQ);
    end
    xfer("irq_stat_kept", 1'b0, A_STAT, 32'h0, 32'h1, 1'b0, 0);
    xfer("irq_stat_clr2", 1'b1, A_STAT, 32'hFF, 32'h0, 1'b0, 0);
    idle();
  endtask

  task automatic test_abort();
    bit seen;
    xfer("abort_wcfg5", 1'b1, A_WCFG, 32'h5, 32'h0, 1'b0, 0);
    idle();
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A_DOUT; PWDATA = 32'h0000_000F;
    @(negedge HCLK);
    PENABLE = 1'b1;
    seen = (PREADY === 1'b1);
    @(negedge HCLK);
    seen |= (PREADY === 1'b1);
    PSEL = 1'b0; PENABLE = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge HCLK);
      seen |= (PREADY === 1'b1);
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL abort_pready: got seen=%b required 0", seen);
    end
    total++;
    if (GPIO_OUT !== 8'hC3) begin
      bad++;
      $display("FAIL abort_no_write: got %h required c3", GPIO_OUT);
    end
    xfer("abort_next_rd", 1'b0, A_DOUT, 32'h0, 32'h0000_00C3, 1'b0, 5);
    idle();
  endtask

  task automatic test_reset_mid();
    int k;
    GPIO_IN = 8'h00;
    repeat (4) idle();
    GPIO_IN = 8'h01;
    xfer("rm_dout_wr", 1'b1, A_DOUT, 32'h81, 32'h0, 1'b0, 5);
    xfer("rm_en_wr",   1'b1, A_EN,   32'h01, 32'h0, 1'b0, 5);
    idle();
    total++;
    if (IRQ !== 1'b1 || GPIO_OUT !== 8'h81) begin
      bad++;
      $display("FAIL rm_pre: got IRQ=%b GPIO_OUT=%h required 1 81", IRQ, GPIO_OUT);
    end
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = A_SCR;
    @(negedge HCLK);
    PENABLE = 1'b1;
    k = 1;
    while (PREADY !== 1'b1 && k < 40) begin
      @(negedge HCLK);
      k++;
    end
    total++;
    if (PREADY !== 1'b1 || PRDATA !== 32'h1234_5678) begin
      bad++;
      $display("FAIL rm_ready: got PREADY=%b PRDATA=%h required 1 12345678", PREADY, PRDATA);
    end
    #1;
    HRESET = 1'b1;
    GPIO_IN = 8'h00;
    #1;
    total++;
    if (PREADY !== 1'b0 || PSLVERR !== 1'b0 || PRDATA !== 32'h0 || IRQ !== 1'b0) begin
      bad++;
      $display("FAIL rm_async: got PREADY=%b PSLVERR=%b PRDATA=%h IRQ=%b required 0", PREADY, PSLVERR, PRDATA, IRQ);
    end
    total++;
    if (GPIO_OUT !== OUT_RST) begin
      bad++;
      $display("FAIL rm_gpio_out: got %h required %h", GPIO_OUT, OUT_RST);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    xfer("rm_wcfg", 1'b0, A_WCFG, 32'h0, {28'h0, WAIT_RST}, 1'b0, WAIT_RST);
    xfer("rm_en",   1'b0, A_EN,   32'h0, 32'h0, 1'b0, WAIT_RST);
    xfer("rm_scr",  1'b0, A_SCR,  32'h0, 32'h0, 1'b0, WAIT_RST);
    xfer("rm_dout", 1'b0, A_DOUT, 32'h0, {24'h0, OUT_RST}, 1'b0, WAIT_RST);
    idle();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_data_in();
    test_wait_states();
    test_errors();
    test_back_to_back();
    test_irq();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
